// File: rtl/prim_ram_arb_pkg.sv
// Shared types and width helpers for the single-port RAM arbiter.
package prim_ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1
  } arb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned addr_width(input int unsigned d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/prim_ram_arb_sel.sv
// Winner selection: request vector (plus round-robin pointer) to one-hot grant and index.
// PRIM_RAM_ARB_RR_EN selects round-robin; otherwise lowest index wins.
module prim_ram_arb_sel
  import prim_ram_arb_pkg::*;
#(
  parameter  int NumReq = 2,
  localparam int IdxW   = idx_width(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
`ifdef PRIM_RAM_ARB_RR_EN
  input  logic [IdxW-1:0]   rr_ptr_i,
`endif
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o
);

`ifdef PRIM_RAM_ARB_RR_EN
  logic            found;
  logic [IdxW:0]   sum;
  logic [IdxW-1:0] cand;

  // Walk the requesters starting at the pointer, wrapping at NumReq.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int off = 0; off < NumReq; off++) begin
      sum = {1'b0, rr_ptr_i} + (IdxW+1)'(off);
      if (sum >= (IdxW+1)'(NumReq)) begin
        sum = sum - (IdxW+1)'(NumReq);
      end
      cand = sum[IdxW-1:0];
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end
`else
  // Descending scan so the lowest requesting index is the last one written.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = IdxW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/prim_ram_1p_arb.sv
// Shares one synchronous single-port RAM between NumReq requesters, zero-filling it after reset
// or on init_req_i. PRIM_RAM_ARB_RR_EN enables round-robin arbitration (default: fixed priority).
module prim_ram_1p_arb
  import prim_ram_arb_pkg::*;
#(
  parameter  int NumReq = 2,
  parameter  int Width  = 32,
  parameter  int Depth  = 128,
  localparam int Aw     = addr_width(Depth),
  localparam int IdxW   = idx_width(NumReq)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         init_req_i,
  output logic                         init_done_o,
  input  logic [NumReq-1:0]            req_i,
  input  logic [NumReq-1:0]            write_i,
  input  logic [NumReq-1:0][Aw-1:0]    addr_i,
  input  logic [NumReq-1:0][Width-1:0] wdata_i,
  input  logic [NumReq-1:0][Width-1:0] wmask_i,
  output logic [NumReq-1:0]            gnt_o,
  output logic [NumReq-1:0]            rvalid_o,
  output logic [Width-1:0]             rdata_o,
  output logic                         ram_req_o,
  output logic                         ram_write_o,
  output logic [Aw-1:0]                ram_addr_o,
  output logic [Width-1:0]             ram_wdata_o,
  output logic [Width-1:0]             ram_wmask_o,
  input  logic [Width-1:0]             ram_rdata_i,
  output arb_state_e                   state_o
);

  // Handshake: a requester holds req/write/addr/wdata/wmask stable until gnt_o is seen in the
  // same cycle; req_i[i] & gnt_o[i] is an accept. An accepted read returns rvalid_o[i] exactly one
  // cycle later with rdata_o valid in that cycle only. Writes never return rvalid.

  arb_state_e               state_q, state_d;
  logic [Aw-1:0]            init_cnt_q, init_cnt_d;
  logic [NumReq-1:0]        rvalid_q;
  logic [NumReq-1:0]        sel_gnt;
  logic [NumReq-1:0]        accept;
  logic [IdxW-1:0]          sel_idx;
  logic                     init_last;

  assign init_last = (init_cnt_q == Aw'(Depth - 1));

`ifdef PRIM_RAM_ARB_RR_EN
  logic [IdxW-1:0] rr_ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (|accept) begin
      rr_ptr_q <= (sel_idx == IdxW'(NumReq - 1)) ? '0 : sel_idx + 1'b1;
    end
  end
`endif

  prim_ram_arb_sel #(
    .NumReq (NumReq)
  ) u_sel (
    .req_i    (req_i),
`ifdef PRIM_RAM_ARB_RR_EN
    .rr_ptr_i (rr_ptr_q),
`endif
    .gnt_o    (sel_gnt),
    .idx_o    (sel_idx)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      rvalid_q   <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rvalid_q   <= accept & ~write_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        if (init_last) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (init_req_i) begin
          state_d    = ST_INIT;
          init_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_INIT;
        init_cnt_d = '0;
      end
    endcase
  end

  // An init request suppresses grants in the cycle it is seen.
  always_comb begin
    gnt_o       = '0;
    ram_req_o   = 1'b0;
    ram_write_o = 1'b0;
    ram_addr_o  = init_cnt_q;
    ram_wdata_o = '0;
    ram_wmask_o = '0;
    case (state_q)
      ST_INIT: begin
        ram_req_o   = 1'b1;
        ram_write_o = 1'b1;
        ram_addr_o  = init_cnt_q;
        ram_wdata_o = '0;
        ram_wmask_o = '1;
      end
      ST_RUN: begin
        if (!init_req_i) begin
          gnt_o       = sel_gnt;
          ram_req_o   = |sel_gnt;
          ram_write_o = write_i[sel_idx];
          ram_addr_o  = addr_i[sel_idx];
          ram_wdata_o = wdata_i[sel_idx];
          ram_wmask_o = wmask_i[sel_idx];
        end
      end
      default: begin
        gnt_o = '0;
      end
    endcase
  end

  assign accept      = req_i & gnt_o;
  assign init_done_o = (state_q == ST_RUN);
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = ram_rdata_i;
  assign state_o     = state_q;

endmodule

// File: tb/tb_prim_ram_1p_arb.sv
// Directed bench for prim_ram_1p_arb with a behavioural single-port RAM attached.
module tb_prim_ram_1p_arb;
  import prim_ram_arb_pkg::*;

  localparam int NumReq = 2;
  localparam int Width  = 32;
  localparam int Depth  = 128;
  localparam int Aw     = 7;

  logic                         clk;
  logic                         rst_ni;
  logic                         init_req_i;
  logic                         init_done_o;
  logic [NumReq-1:0]            req_i;
  logic [NumReq-1:0]            write_i;
  logic [NumReq-1:0][Aw-1:0]    addr_i;
  logic [NumReq-1:0][Width-1:0] wdata_i;
  logic [NumReq-1:0][Width-1:0] wmask_i;
  logic [NumReq-1:0]            gnt_o;
  logic [NumReq-1:0]            rvalid_o;
  logic [Width-1:0]             rdata_o;
  logic                         ram_req_o;
  logic                         ram_write_o;
  logic [Aw-1:0]                ram_addr_o;
  logic [Width-1:0]             ram_wdata_o;
  logic [Width-1:0]             ram_wmask_o;
  logic [Width-1:0]             ram_rdata_i;
  arb_state_e                   state;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  logic [Width-1:0] exp_q[$];
  logic [Width-1:0] mem [Depth];

  prim_ram_1p_arb #(
    .NumReq (NumReq),
    .Width  (Width),
    .Depth  (Depth)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .init_req_i  (init_req_i),
    .init_done_o (init_done_o),
    .req_i       (req_i),
    .write_i     (write_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .wmask_i     (wmask_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .ram_req_o   (ram_req_o),
    .ram_write_o (ram_write_o),
    .ram_addr_o  (ram_addr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_wmask_o (ram_wmask_o),
    .ram_rdata_i (ram_rdata_i),
    .state_o     (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // RAM macro: loaded with a non-zero pattern while in reset so zero-fill is observable.
  always @(posedge clk) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem[i] <= 32'hA5A5_5A5A;
    end else if (ram_req_o) begin
      if (ram_write_o) begin
        mem[ram_addr_o] <= (mem[ram_addr_o] & ~ram_wmask_o) | (ram_wdata_o & ram_wmask_o);
        wr_cnt <= wr_cnt + 1;
      end else begin
        ram_rdata_i <= mem[ram_addr_o];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // driver tasks: inputs change on negedge, outputs sampled 2 time units later
  task automatic do_write(input int r, input logic [Aw-1:0] a, input logic [Width-1:0] d,
                          input logic [Width-1:0] m);
    logic [1:0] g;
    g = 2'b01 << r;
    @(negedge clk);
    req_i[r] = 1'b1; write_i[r] = 1'b1; addr_i[r] = a; wdata_i[r] = d; wmask_i[r] = m;
    #2 check("wr_gnt", 64'(gnt_o), 64'(g));
    @(negedge clk);
    req_i[r] = 1'b0; write_i[r] = 1'b0;
    #2 check("wr_no_rvalid", 64'(rvalid_o), 64'(0));
  endtask

  task automatic do_read(input int r, input logic [Aw-1:0] a, input logic [Width-1:0] exp);
    logic [1:0] g;
    g = 2'b01 << r;
    @(negedge clk);
    req_i[r] = 1'b1; write_i[r] = 1'b0; addr_i[r] = a;
    #2 check("rd_gnt", 64'(gnt_o), 64'(g));
    @(negedge clk);
    req_i[r] = 1'b0;
    #2 check("rd_rvalid", 64'(rvalid_o), 64'(g));
    check("rd_data", 64'(rdata_o), 64'(exp));
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!init_done_o && n < 300) begin
      @(negedge clk);
      #2 n++;
    end
  endtask

  function automatic logic [1:0] exp_g(input int k);
`ifdef PRIM_RAM_ARB_RR_EN
    return (k % 2 == 0) ? 2'b01 : 2'b10;
`else
    return 2'b01;
`endif
  endfunction

  initial begin
    int n;
    int wr0;
    rst_ni = 1'b0; init_req_i = 1'b0;
    req_i = '0; write_i = '0; addr_i = '0; wdata_i = '0; wmask_i = '0;

    // 1: reset values, then exactly Depth zero writes at 0..Depth-1
    repeat (2) @(negedge clk);
    #2;
    check("rst_state", 64'(state), 64'(ST_INIT));
    check("rst_done", 64'(init_done_o), 64'(0));
    check("rst_gnt_rvalid", 64'({gnt_o, rvalid_o}), 64'(0));
    check("rst_ram_addr", 64'(ram_addr_o), 64'(0));
    @(negedge clk);
    rst_ni = 1'b1;
    wr0 = wr_cnt;
    #2 check("init_addr", 64'(ram_addr_o), 64'(0));
    for (int i = 1; i < Depth; i++) begin
      @(negedge clk);
      #2;
      check("init_addr", 64'(ram_addr_o), 64'(i));
      check("init_ctl", 64'({ram_req_o, ram_write_o, gnt_o, init_done_o}), 64'(5'b11000));
      check("init_data", 64'({ram_wdata_o, ram_wmask_o}), {32'h0, 32'hFFFF_FFFF});
    end
    @(negedge clk);
    #2;
    check("init_done", 64'(init_done_o), 64'(1));
    check("init_state", 64'(state), 64'(ST_RUN));
    check("init_wr_cnt", 64'(wr_cnt - wr0), 64'(Depth));
    check("run_idle_ram_req", 64'(ram_req_o), 64'(0));

    // 2: write then read back on requester 0
    do_write(0, 7'd5, 32'h1234_5678, 32'hFFFF_FFFF);
    do_read(0, 7'd5, 32'h1234_5678);

    // 3: both requesters reading concurrently; last accept by req1 leaves the pointer at 0
    do_write(0, 7'd1, 32'h1111_0001, 32'hFFFF_FFFF);
    do_write(1, 7'd2, 32'h2222_0002, 32'hFFFF_FFFF);
    @(negedge clk);
    req_i = 2'b11; write_i = 2'b00; addr_i[0] = 7'd1; addr_i[1] = 7'd2;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #2;
      check("both_gnt", 64'(gnt_o), 64'(exp_g(k)));
      if (k > 0) begin
        check("both_rvalid", 64'(rvalid_o), 64'(exp_g(k - 1)));
        check("both_rdata", 64'(rdata_o), 64'(exp_q.pop_front()));
      end
      exp_q.push_back((exp_g(k) == 2'b01) ? 32'h1111_0001 : 32'h2222_0002);
    end
    @(negedge clk);
    req_i = 2'b00;
    #2;
    check("both_rvalid_last", 64'(rvalid_o), 64'(exp_g(5)));
    check("both_rdata_last", 64'(rdata_o), 64'(exp_q.pop_front()));

    // 4: partial write mask
    do_write(1, 7'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_write(1, 7'd9, 32'hAAAA_BBBB, 32'h0000_FFFF);
    do_read(1, 7'd9, 32'hFFFF_BBBB);

    // 5: read accepted at T, init_req at T+1
    @(negedge clk);
    req_i[0] = 1'b1; write_i[0] = 1'b0; addr_i[0] = 7'd5;
    #2 check("t5_gnt_T", 64'(gnt_o), 64'(2'b01));
    @(negedge clk);
    req_i = 2'b10; addr_i[1] = 7'd9; init_req_i = 1'b1;
    #2;
    check("t5_gnt_T1", 64'(gnt_o), 64'(0));
    check("t5_ram_req_T1", 64'(ram_req_o), 64'(0));
    check("t5_rvalid_T1", 64'(rvalid_o), 64'(2'b01));
    check("t5_rdata_T1", 64'(rdata_o), 64'(32'h1234_5678));
    @(negedge clk);
    init_req_i = 1'b0;
    #2;
    check("t5_done_T2", 64'(init_done_o), 64'(0));
    check("t5_gnt_T2", 64'(gnt_o), 64'(0));
    check("t5_rvalid_T2", 64'(rvalid_o), 64'(0));
    check("t5_addr_T2", 64'(ram_addr_o), 64'(0));
    req_i = 2'b00;
    wait_init(n);
    check("t5_reinit_cycles", 64'(n), 64'(Depth));
    do_read(0, 7'd5, 32'h0);
    do_read(1, 7'd9, 32'h0);
    do_read(0, 7'd1, 32'h0);

    // 6: reset drops a pending rvalid; reset mid-init restarts from address 0
    do_write(0, 7'd3, 32'hCAFE_F00D, 32'hFFFF_FFFF);
    @(negedge clk);
    req_i[0] = 1'b1; write_i[0] = 1'b0; addr_i[0] = 7'd3;
    #2 check("t6_gnt", 64'(gnt_o), 64'(2'b01));
    @(negedge clk);
    req_i = 2'b00;
    rst_ni = 1'b0;
    #2 check("t6_rvalid_dropped", 64'(rvalid_o), 64'(0));
    @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 1; i <= 40; i++) @(negedge clk);
    #2 check("t6_addr40", 64'(ram_addr_o), 64'(40));
    @(negedge clk);
    rst_ni = 1'b0;
    #2;
    check("t6_rst_state", 64'(state), 64'(ST_INIT));
    check("t6_rst_addr", 64'(ram_addr_o), 64'(0));
    check("t6_rst_outs", 64'({init_done_o, gnt_o, rvalid_o, ram_req_o, ram_write_o}), 64'(6'b000011));
    @(negedge clk);
    rst_ni = 1'b1;
    #2 check("t6_restart_addr", 64'(ram_addr_o), 64'(0));
    @(negedge clk);
    #2 check("t6_restart_addr1", 64'(ram_addr_o), 64'(1));
    wait_init(n);
    check("t6_reinit_cycles", 64'(n), 64'(Depth - 1));
    do_read(0, 7'd3, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
